// File: rtl/mux_gpr.sv
// Operand bypass mux: combinational select between write-back and register-file
// data, plus registered copies of the result/select and a saturating bypass counter.
module mux_gpr #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] wd,
  input  logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] out,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_q,
  output logic [CNT_W-1:0] bypass_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] out_d;
  logic             sel_d;
  logic [CNT_W-1:0] bypass_cnt_d;
  logic [CNT_W-1:0] bypass_cnt_q;

  // Operand select; stays live during reset.
  assign out = sel ? wd : rdata;

  // Next-state: registered copies and a counter that sticks at all-ones.
  always_comb begin
    out_d        = out;
    sel_d        = sel;
    bypass_cnt_d = bypass_cnt_q;
    if (sel && (bypass_cnt_q != CNT_MAX)) begin
      bypass_cnt_d = bypass_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      sel_q        <= 1'b0;
      bypass_cnt_q <= '0;
    end else begin
      out_q        <= out_d;
      sel_q        <= sel_d;
      bypass_cnt_q <= bypass_cnt_d;
    end
  end

  assign bypass_cnt = bypass_cnt_q;

endmodule

// File: tb/tb_mux_gpr.sv
// Self-checking bench for mux_gpr: default instance plus a 4-bit-counter
// instance sharing the same stimulus; expected registered state flows through a queue.
module tb_mux_gpr;

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic        sel;
  logic [31:0] wd;
  logic [31:0] rdata;
  logic [31:0] out;
  logic [31:0] out_q;
  logic        sel_q;
  logic [15:0] bypass_cnt;
  logic [31:0] out4;
  logic [31:0] out_q4;
  logic        sel_q4;
  logic [3:0]  bypass_cnt4;

  int n_checks;
  int n_errors;

  typedef struct packed {
    logic [31:0] oq;
    logic        sq;
    logic [15:0] c16;
    logic [3:0]  c4;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] m_c16;
  logic [3:0]  m_c4;

  mux_gpr u_dut (
    .sel        (sel),
    .wd         (wd),
    .rdata      (rdata),
    .out        (out),
    .clk        (clk),
    .rst        (rst),
    .out_q      (out_q),
    .sel_q      (sel_q),
    .bypass_cnt (bypass_cnt)
  );

  mux_gpr #(.WIDTH(32), .CNT_W(4)) u_dut4 (
    .sel        (sel),
    .wd         (wd),
    .rdata      (rdata),
    .out        (out4),
    .clk        (clk),
    .rst        (rst),
    .out_q      (out_q4),
    .sel_q      (sel_q4),
    .bypass_cnt (bypass_cnt4)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one vector, check the mux, queue the post-edge state, then compare after the edge.
  task automatic step(input logic s, input logic [31:0] w, input logic [31:0] r);
    exp_t e;
    sel   = s;
    wd    = w;
    rdata = r;
    #1;
    check("out", out, s ? w : r);
    check("out4", out4, s ? w : r);
    if (s && m_c16 != 16'hFFFF) m_c16 = m_c16 + 16'd1;
    if (s && m_c4 != 4'hF) m_c4 = m_c4 + 4'd1;
    e.oq  = s ? w : r;
    e.sq  = s;
    e.c16 = m_c16;
    e.c4  = m_c4;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check("sb_depth", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("out_q", out_q, e.oq);
      check("sel_q", 32'(sel_q), 32'(e.sq));
      check("cnt16", 32'(bypass_cnt), 32'(e.c16));
      check("cnt4", 32'(bypass_cnt4), 32'(e.c4));
      check("out_q4", out_q4, e.oq);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out_q"}, out_q, 32'h0);
    check({tag, "_sel_q"}, 32'(sel_q), 32'h0);
    check({tag, "_cnt16"}, 32'(bypass_cnt), 32'h0);
    check({tag, "_cnt4"}, 32'(bypass_cnt4), 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_c16    = '0;
    m_c4     = '0;
    clk_en   = 1'b0;
    rst      = 1'b1;
    sel      = 1'b0;
    wd       = 32'hDEADBEEF;
    rdata    = 32'h12345678;

    // Reset with no clock; mux stays live.
    #1;
    check_cleared("rst_noclk");
    check("mux_sel0", out, 32'h12345678);
    sel = 1'b1;
    #0;
    #0;
    check("mux_sel1_same_ts", out, 32'hDEADBEEF);
    #1;
    wd = 32'hCAFEF00D;
    sel = 1'b0;
    rdata = 32'h0BADF00D;
    #1;
    check("mux_simul_change", out, 32'h0BADF00D);
    rst = 1'b0;
    #1;
    check_cleared("post_rst");

    clk_en = 1'b1;
    @(negedge clk);

    // First edge after reset: registered copy scenario.
    step(1'b1, 32'h0000000A, 32'h55555555);
    check("reg_copy_out_q", out_q, 32'h0000000A);
    check("reg_copy_sel_q", 32'(sel_q), 32'h1);
    check("reg_copy_cnt", 32'(bypass_cnt), 32'h1);

    // Saturation of the 4-bit counter and hold on sel=0.
    for (int i = 0; i < 20; i++) step(1'b1, $urandom, $urandom);
    check("sat4_after20", 32'(bypass_cnt4), 32'hF);
    check("cnt16_after21", 32'(bypass_cnt), 32'd21);
    for (int i = 0; i < 3; i++) step(1'b0, $urandom, $urandom);
    check("sat4_hold_sel0", 32'(bypass_cnt4), 32'hF);
    check("cnt16_hold_sel0", 32'(bypass_cnt), 32'd21);

    // Mid-operation reset pulse between edges.
    rst = 1'b1;
    #1;
    check_cleared("rst_mid_a");
    rst = 1'b0;
    m_c16 = '0;
    m_c4  = '0;
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, $urandom);
    check("cnt_is5", 32'(bypass_cnt), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    check_cleared("rst_mid_b");
    check("out_live_in_rst", out, sel ? wd : rdata);
    rst = 1'b0;
    m_c16 = '0;
    m_c4  = '0;
    step(1'b1, 32'h00000077, 32'h00000088);
    check("cnt_after_rst", 32'(bypass_cnt), 32'd1);

    // Random vectors.
    for (int i = 0; i < 1000; i++) step(1'($urandom), $urandom, $urandom);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
